pc_unit: RTL and testbench

Program counter for the tinyGPU scheduler. Holds the current instruction-memory address, drives it straight onto the instruction-memory address bus, and updates it once per clock: hold, increment, or load a branch target. A small return-address stack supports call and return. Module name: `pc_unit`.

---
 rtl/pc_unit_pkg.sv | 24 ++
 rtl/pc_unit_if.sv | 24 ++
 rtl/pc_ret_stack.sv | 37 +++
 rtl/pc_unit.sv | 71 +++++++
 tb/tb_pc_unit.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/pc_unit_pkg.sv
// Shared constants and the action decode for the tinyGPU program counter.
package pc_unit_pkg;

  localparam int INSTMEM_ADDR_WIDTH = 16;
  localparam logic [INSTMEM_ADDR_WIDTH-1:0] DEFAULT_RESET_ADDR = '0;

  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_INC,
    ACT_LOAD,
    ACT_CALL,
    ACT_RET
  } pc_act_e;

  // Exactly one action per edge; return outranks call, which outranks load and increment.
  function automatic pc_act_e pick_action(logic ret, logic call, logic load, logic inc);
    if (ret)       return ACT_RET;
    else if (call) return ACT_CALL;
    else if (load) return ACT_LOAD;
    else if (inc)  return ACT_INC;
    else           return ACT_HOLD;
  endfunction

endpackage

// File: rtl/pc_unit_if.sv
// Scheduler-side control/status bundle for the program counter.
interface pc_unit_if #(
  parameter int AW = 16
);
  logic          incPC;
  logic          loadFromI;
  logic [AW-1:0] I;
  logic          call;
  logic          ret;
  logic [AW-1:0] AR;
  logic          stack_full;
  logic          stack_empty;
  logic          stack_err;

  modport master (
    output incPC, loadFromI, I, call, ret,
    input  AR, stack_full, stack_empty, stack_err
  );

  modport slave (
    input  incPC, loadFromI, I, call, ret,
    output AR, stack_full, stack_empty, stack_err
  );
endinterface

// File: rtl/pc_ret_stack.sv
// Return-address LIFO; the top entry is always presented combinationally.
module pc_ret_stack #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top_data,
  output logic         full,
  output logic         empty
);
  localparam int PTR_W = $clog2(DEPTH) + 1;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_dec;

  assign ptr_dec  = ptr - PTR_W'(1);
  assign top_data = mem[ptr_dec[IDX_W-1:0]];
  assign full     = (ptr == PTR_W'(DEPTH));
  assign empty    = (ptr == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    ptr <= '0;
    else if (push) ptr <= ptr + PTR_W'(1);
    else if (pop)  ptr <= ptr_dec;
  end

  // Entries need no reset: only the pointer decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[ptr[IDX_W-1:0]] <= push_data;
  end
endmodule

// File: rtl/pc_unit.sv
// Program counter: AR register, priority next-PC mux, incrementer,
// return-address stack and sticky stack error flag.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = INSTMEM_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR  = ADDR_WIDTH'(DEFAULT_RESET_ADDR),
  parameter int                    STACK_DEPTH = 4
) (
  input  logic                  clk,
  output logic [ADDR_WIDTH-1:0] AR,
  input  logic                  incPC,
  input  logic                  loadFromI,
  input  logic [ADDR_WIDTH-1:0] I,
  input  logic                  reset,
  input  logic                  call,
  input  logic                  ret,
  output logic                  stack_full,
  output logic                  stack_empty,
  output logic                  stack_err
);
  pc_act_e               act;
  logic [ADDR_WIDTH-1:0] ar_inc;
  logic [ADDR_WIDTH-1:0] top_data;
  logic                  push;
  logic                  pop;
  logic                  err_q;

  assign act    = pick_action(ret, call, loadFromI, incPC);
  assign ar_inc = AR + ADDR_WIDTH'(1);
  assign push   = (act == ACT_CALL) && !stack_full;
  assign pop    = (act == ACT_RET) && !stack_empty;

  pc_ret_stack #(
    .W     (ADDR_WIDTH),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk       (clk),
    .rst_n     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (ar_inc),
    .top_data  (top_data),
    .full      (stack_full),
    .empty     (stack_empty)
  );

  // A call on a full stack still jumps; only the return address is lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      AR    <= RESET_ADDR;
      err_q <= 1'b0;
    end else begin
      unique case (act)
        ACT_RET: begin
          if (stack_empty) err_q <= 1'b1;
          else             AR    <= top_data;
        end
        ACT_CALL: begin
          AR <= I;
          if (stack_full) err_q <= 1'b1;
        end
        ACT_LOAD: AR <= I;
        ACT_INC:  AR <= ar_inc;
        default:  ;
      endcase
    end
  end

  assign stack_err = err_q;
endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: directed scenarios then randomized control mixes
// against a queue-based reference model of the counter and return stack.
module tb_pc_unit;
  localparam int AW    = 16;
  localparam int DEPTH = 4;

  typedef struct {
    int ar;
    bit full;
    bit empty;
    bit err;
  } exp_t;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  exp_t exp_q[$];

  // reference model state
  int   m_ar;
  int   m_stk[$];
  bit   m_err;

  pc_unit_if #(.AW(AW)) bus ();

  pc_unit #(
    .ADDR_WIDTH  (AW),
    .RESET_ADDR  ('0),
    .STACK_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .AR          (bus.AR),
    .incPC       (bus.incPC),
    .loadFromI   (bus.loadFromI),
    .I           (bus.I),
    .reset       (reset),
    .call        (bus.call),
    .ret         (bus.ret),
    .stack_full  (bus.stack_full),
    .stack_empty (bus.stack_empty),
    .stack_err   (bus.stack_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic exp_t snapshot();
    exp_t e;
    e.ar    = m_ar;
    e.full  = (m_stk.size() == DEPTH);
    e.empty = (m_stk.size() == 0);
    e.err   = m_err;
    return e;
  endfunction

  function automatic void model_reset();
    m_ar = 0;
    m_stk.delete();
    m_err = 1'b0;
  endfunction

  function automatic void model_step(bit inc, bit ld, int i, bit cl, bit rt);
    if (rt) begin
      if (m_stk.size() > 0) m_ar = m_stk.pop_back();
      else                  m_err = 1'b1;
    end else if (cl) begin
      if (m_stk.size() < DEPTH) m_stk.push_back((m_ar + 1) % (1 << AW));
      else                      m_err = 1'b1;
      m_ar = i;
    end else if (ld) begin
      m_ar = i;
    end else if (inc) begin
      m_ar = (m_ar + 1) % (1 << AW);
    end
  endfunction

  // Apply one cycle of controls; the expectation for the following edge is queued.
  task automatic drive(input bit inc, input bit ld, input int i, input bit cl, input bit rt);
    @(negedge clk);
    bus.incPC     = inc;
    bus.loadFromI = ld;
    bus.I         = i[AW-1:0];
    bus.call      = cl;
    bus.ret       = rt;
    model_step(inc, ld, i, cl, rt);
    exp_q.push_back(snapshot());
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  // Assert reset mid-cycle with busy controls, check the asynchronous effect,
  // hold across an edge, then release with quiet controls.
  task automatic do_reset();
    @(negedge clk);
    bus.incPC     = 1'b1;
    bus.loadFromI = 1'b1;
    bus.I         = 16'hBEEF;
    bus.call      = 1'b1;
    bus.ret       = 1'b1;
    #2 reset = 1'b0;
    #1;
    model_reset();
    check("rst_async_ar", int'(bus.AR), 0);
    check("rst_async_empty", int'(bus.stack_empty), 1);
    check("rst_async_full", int'(bus.stack_full), 0);
    check("rst_async_err", int'(bus.stack_err), 0);
    @(posedge clk);
    #1;
    check("rst_held_ar", int'(bus.AR), 0);
    @(negedge clk);
    bus.incPC     = 1'b0;
    bus.loadFromI = 1'b0;
    bus.call      = 1'b0;
    bus.ret       = 1'b0;
    reset         = 1'b1;
  endtask

  // Monitor: after every rising edge, compare against the oldest pending expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("ar", int'(bus.AR), e.ar);
        check("full", int'(bus.stack_full), int'(e.full));
        check("empty", int'(bus.stack_empty), int'(e.empty));
        check("err", int'(bus.stack_err), int'(e.err));
      end
    end
  end

  initial begin
    bus.incPC     = 1'b0;
    bus.loadFromI = 1'b0;
    bus.I         = '0;
    bus.call      = 1'b0;
    bus.ret       = 1'b0;
    reset         = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);

    // Reset from an arbitrary AR, then quiet controls hold 0
    drive(1'b0, 1'b1, 16'h5A5A, 1'b0, 1'b0);
    do_reset();
    idle();

    // Increment run and hold
    repeat (3) drive(1'b1, 1'b0, 0, 1'b0, 1'b0);
    idle();

    // Load beats increment, and repeats while held
    repeat (3) drive(1'b1, 1'b1, 16'h0004, 1'b0, 1'b0);

    // Wrap
    drive(1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 0, 1'b0, 1'b0);

    // Call / return
    drive(1'b0, 1'b1, 16'h0010, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 16'h0100, 1'b1, 1'b0);
    repeat (2) drive(1'b1, 1'b0, 0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 0, 1'b0, 1'b1);

    // Overflow: DEPTH+1 calls
    for (int k = 0; k <= DEPTH; k++) drive(1'b0, 1'b0, 16'h0200 + k * 16'h10, 1'b1, 1'b0);
    idle();

    // Underflow after reset, then reset clears the sticky flag
    do_reset();
    drive(1'b0, 1'b1, 16'h1234, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 16'h4321, 1'b0, 1'b1);
    idle();
    do_reset();
    idle();

    // Randomized control mixes with independent request bits to exercise priority
    for (int n = 0; n < 600; n++) begin
      int  iv;
      bit  inc, ld, cl, rt;
      if ($urandom_range(0, 79) == 0) do_reset();
      case ($urandom_range(0, 3))
        0:       iv = 16'hFFFF;
        1:       iv = 16'hFFFE;
        default: iv = int'($urandom_range(0, 16'hFFFF));
      endcase
      inc = ($urandom_range(0, 99) < 50);
      ld  = ($urandom_range(0, 99) < 15);
      cl  = ($urandom_range(0, 99) < 14);
      rt  = ($urandom_range(0, 99) < 14);
      drive(inc, ld, iv, cl, rt);
    end

    // Drain the scoreboard within a bounded number of cycles
    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
